// File: rtl/div_unit_pkg.sv
// Shared encodings and constants for the EX-stage divider and the result bus.
package div_unit_pkg;

  // Divider FSM state encodings
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // {HI, LO} bus carried from EX through MEM to WB
  localparam int RESULT_BUS_W = 64;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV / DIVU), one quotient bit per cycle.
// Result is {remainder, quotient}; WB splits it into HI / LO.
import div_unit_pkg::*;

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quot, r_divisor;
  logic             r_neg_q, r_neg_r;

  logic             w_accept, w_byzero;
  logic [WIDTH-1:0] w_abs1, w_abs2;
  logic [WIDTH:0]   w_part_hi;
  logic [WIDTH+1:0] w_trial;
  logic [WIDTH-1:0] w_rem_nxt, w_quot_nxt, w_rem_fix, w_quot_fix;

  assign w_accept = start_i && !annul_i;
  assign w_byzero = (opdata2_i == '0);

  // Magnitudes of the operands; only signed ops with a negative operand are flipped
  assign w_abs1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Restoring step: the shifted remainder can need one bit more than WIDTH
  // when the divisor is above 2^(WIDTH-1), hence the widened trial subtract.
  assign w_part_hi  = {r_rem, r_quot[WIDTH-1]};
  assign w_trial    = {1'b0, w_part_hi} - {2'b00, r_divisor};
  assign w_rem_nxt  = w_trial[WIDTH+1] ? w_part_hi[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quot_nxt = {r_quot[WIDTH-2:0], ~w_trial[WIDTH+1]};

  // Sign fix-up: quotient negative when signs differ, remainder follows the dividend
  assign w_quot_fix = r_neg_q ? -w_quot_nxt : w_quot_nxt;
  assign w_rem_fix  = r_neg_r ? -w_rem_nxt  : w_rem_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= DivFree;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; annul always returns to idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DivFree:   if (w_accept) w_state_nxt = w_byzero ? DivByZero : DivOn;
      DivByZero: w_state_nxt = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)                 w_state_nxt = DivFree;
        else if (r_cnt == LAST_STEP) w_state_nxt = DivEnd;
      end
      DivEnd:    if (annul_i || !start_i) w_state_nxt = DivFree;
      default:   w_state_nxt = DivFree;
    endcase
  end

  // Stall the pipeline from the accepting cycle until the result is ready
  always_comb begin
    stallreq_o = 1'b0;
    case (r_state)
      DivFree:   stallreq_o = w_accept;
      DivByZero: stallreq_o = 1'b1;
      DivOn:     stallreq_o = 1'b1;
      default:   stallreq_o = 1'b0;
    endcase
  end

  // Operand capture, shift/subtract datapath and registered result
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          if (w_accept) begin
            // Divide-by-zero keeps the raw dividend for the HI half
            r_quot    <= w_byzero ? opdata1_i : w_abs1;
            r_rem     <= '0;
            r_divisor <= w_abs2;
            r_cnt     <= '0;
            r_neg_q   <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_r   <= signed_i && opdata1_i[WIDTH-1];
          end
        end
        DivByZero: begin
          if (!annul_i) begin
            result_o <= {r_quot, {WIDTH{1'b1}}};
            ready_o  <= DivResultReady;
          end
        end
        DivOn: begin
          if (!annul_i) begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) begin
              result_o <= {w_rem_fix, w_quot_fix};
              ready_o  <= DivResultReady;
            end
          end
        end
        DivEnd: begin
          if (annul_i || !start_i) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of divides plus annul / hold / reset sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i, annul_i, signed_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  int n_vec = 0;
  int n_err = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .annul_i(annul_i),
    .signed_i(signed_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle start is raised; returns cycles until ready_o and whether
  // stallreq_o stayed high in every cycle before it.
  task automatic wait_ready(output int lat, output bit stall_ok);
    bit got;
    got = 0; lat = 0; stall_ok = 1;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (ready_o) got = 1;
      else begin
        if (stallreq_o !== 1'b1) stall_ok = 0;
        step();
        lat++;
      end
    end
  endtask

  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
  endtask

  task automatic run_vec(input int idx);
    int lat; bit sok;
    launch(vecs[idx].sgn, vecs[idx].a, vecs[idx].b);
    wait_ready(lat, sok);
    check($sformatf("v%0d latency", idx), 64'(lat), 64'(vecs[idx].lat));
    check($sformatf("v%0d stall busy", idx), 64'(sok), 64'd1);
    check($sformatf("v%0d result", idx), result_o, vecs[idx].exp);
    check($sformatf("v%0d stall in ready", idx), 64'(stallreq_o), 64'd0);
    start_i = 1'b0;
    step();
    @(negedge clk);
    check($sformatf("v%0d drop ready", idx), 64'(ready_o), 64'd0);
    check($sformatf("v%0d drop result", idx), result_o, 64'd0);
    step();
  endtask

  initial begin
    int lat; bit sok, hold_ok;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2]  = '{1'b0, 32'd5,          32'd0,          64'h00000005_FFFFFFFF, 2};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
    vecs[4]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
    vecs[5]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 33};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   64'h00000001_00000001, 33};
    vecs[7]  = '{1'b0, 32'h80000001,   32'h80000000,   64'h00000001_00000001, 33};
    vecs[8]  = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 33};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
    vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'd0,          64'hFFFFFFF9_FFFFFFFF, 2};
    vecs[11] = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33};

    resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    step(); step();
    @(negedge clk);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset stall", 64'(stallreq_o), 64'd0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 12; i++) run_vec(i);

    // Annul mid-divide, then a fresh divide two cycles later
    launch(1'b0, 32'd1000, 32'd3);
    for (int c = 0; c < 10; c++) step();
    annul_i = 1'b1; start_i = 1'b0;
    step();
    annul_i = 1'b0;
    @(negedge clk);
    check("annul stall", 64'(stallreq_o), 64'd0);
    check("annul ready", 64'(ready_o), 64'd0);
    step();
    launch(1'b0, 32'd9, 32'd3);
    wait_ready(lat, sok);
    check("post-annul latency", 64'(lat), 64'd33);
    check("post-annul result", result_o, 64'h00000000_00000003);
    start_i = 1'b0;
    step(); step();

    // Hold start in END: result stays put, then drop
    launch(1'b0, 32'd100, 32'd7);
    wait_ready(lat, sok);
    hold_ok = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge clk);
      if (!ready_o || result_o !== 64'h00000002_0000000E || stallreq_o) hold_ok = 0;
    end
    check("hold stable", 64'(hold_ok), 64'd1);
    start_i = 1'b0;
    step();
    @(negedge clk);
    check("hold drop ready", 64'(ready_o), 64'd0);
    check("hold drop result", result_o, 64'd0);
    step();

    // Annul while held in END behaves like dropping start
    launch(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_ready(lat, sok);
    annul_i = 1'b1;
    step();
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("end annul ready", 64'(ready_o), 64'd0);
    check("end annul result", result_o, 64'd0);
    step();

    // Reset while a result is being held
    launch(1'b0, 32'd100, 32'd7);
    wait_ready(lat, sok);
    resetn = 1'b0; start_i = 1'b0;
    step();
    @(negedge clk);
    check("reset in END result", result_o, 64'd0);
    check("reset in END ready", 64'(ready_o), 64'd0);
    resetn = 1'b1;
    step();

    // Reset in cycle 20 of a fresh divide
    launch(1'b0, 32'd1000, 32'd3);
    for (int c = 0; c < 20; c++) step();
    resetn = 1'b0; start_i = 1'b0;
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("mid reset ready", 64'(ready_o), 64'd0);
    check("mid reset result", result_o, 64'd0);
    check("mid reset stall", 64'(stallreq_o), 64'd0);
    hold_ok = 1;
    for (int c = 0; c < 40; c++) begin
      step();
      @(negedge clk);
      if (ready_o || stallreq_o) hold_ok = 0;
    end
    check("mid reset stays idle", 64'(hold_ok), 64'd1);
    step();

    // Divider still healthy after reset
    launch(1'b0, 32'd100, 32'd7);
    wait_ready(lat, sok);
    check("after reset latency", 64'(lat), 64'd33);
    check("after reset result", result_o, 64'h00000002_0000000E);
    start_i = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
